// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl - instruction fetch controller with a 2-entry fetch buffer.
//
// Fetches one 32-bit word per cycle from a combinational instruction memory
// and buffers {pc, instr} pairs for a ready/valid consumer. Supports halt,
// single-cycle redirect (flush) and asynchronous reset.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   im_addr        out  [31:0] byte address to instruction memory (= pc)
//   im_data        in   [31:0] instruction word for im_addr, same cycle
//   halt           in   level; stops new fetches while high
//   redirect_valid in   single-cycle request to restart fetch at redirect_pc
//   redirect_pc    in   [31:0] redirect target (low two bits ignored)
//   out_valid      out  buffer head holds a valid instruction
//   out_ready      in   consumer accepts the head this cycle
//   out_instr      out  [31:0] instruction at buffer head
//   out_pc         out  [31:0] byte address of out_instr
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [1:0]  FULL_COUNT       = 2'(DEPTH);

  logic [31:0] pc, pc_next;
  logic [31:0] fifo_pc [0:1];
  logic [31:0] fifo_instr [0:1];
  logic [31:0] fifo_pc_next [0:1];
  logic [31:0] fifo_instr_next [0:1];
  logic        rd_ptr, rd_next;
  logic        wr_ptr, wr_next;
  logic [1:0]  count, count_next;
  logic [31:0] head_pc, head_pc_next;
  logic [31:0] head_instr, head_instr_next;
  logic        deq, enq;

  // Redirect targets are word aligned; the dropped bits are intentionally unused.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign im_addr   = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head_instr;
  assign out_pc    = head_pc;

  assign deq = out_valid & out_ready;
  // A full buffer can still accept a word when the head leaves in the same cycle.
  assign enq = !halt && !redirect_valid && ((count < FULL_COUNT) || deq);

  always_comb begin
    pc_next         = pc;
    rd_next         = rd_ptr;
    wr_next         = wr_ptr;
    count_next      = count;
    fifo_pc_next    = fifo_pc;
    fifo_instr_next = fifo_instr;
    head_pc_next    = head_pc;
    head_instr_next = head_instr;

    if (redirect_valid) begin
      // Flush: any handshake this cycle is honoured, but its entry is dropped.
      pc_next    = {redirect_pc[31:2], 2'b00};
      count_next = 2'd0;
      rd_next    = 1'b0;
      wr_next    = 1'b0;
    end else begin
      if (enq) begin
        fifo_pc_next[wr_ptr]    = pc;
        fifo_instr_next[wr_ptr] = im_data;
        pc_next                 = pc + 32'd4;
        wr_next                 = ~wr_ptr;
      end
      if (deq) begin
        rd_next = ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
      // Head outputs are registered copies of the next head so that im_data
      // never reaches out_* combinationally; an empty buffer holds the last head.
      if (count_next != 2'd0) begin
        head_pc_next    = fifo_pc_next[rd_next];
        head_instr_next = fifo_instr_next[rd_next];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC_ALIGNED;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      head_pc    <= 32'd0;
      head_instr <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'd0;
        fifo_instr[i] <= 32'd0;
      end
    end else begin
      pc         <= pc_next;
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      head_pc    <= head_pc_next;
      head_instr <= head_instr_next;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= fifo_pc_next[i];
        fifo_instr[i] <= fifo_instr_next[i];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl - self-checking bench for ifetch_ctrl.
//
// The instruction memory model returns word index i for byte address 4*i.
// Expected {pc} sequences are pushed to a scoreboard queue when stimulus is
// set up and popped as the DUT presents each buffer head.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  ifetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .im_addr(im_addr),
    .im_data(im_data),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  assign im_data = im_addr >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and release it right after an edge; the next edge may fetch.
  task automatic apply_reset(input logic ready);
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = ready;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (im_addr !== 32'd0) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 00000000", im_addr); end
    n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("[TB] FAIL reset_out_pc: got %h want 00000000", out_pc); end
    n_cmp++; if (out_instr !== 32'd0) begin n_err++; $display("[TB] FAIL reset_out_instr: got %h want 00000000", out_instr); end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    apply_reset(1'b1);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 10; i++) begin
      step();
      exp_pc = exp_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc >> 2)) begin n_err++; $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, out_instr, exp_pc >> 2); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    repeat (5) step();
    n_cmp++; if (im_addr !== 32'd8) begin n_err++; $display("[TB] FAIL bp_pc_stop: got %h want 00000008", im_addr); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("[TB] FAIL bp_head: got %h want 00000000", out_pc); end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("[TB] FAIL bp_drain_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc >> 2)) begin n_err++; $display("[TB] FAIL bp_drain_instr[%0d]: got %h want %h", i, out_instr, exp_pc >> 2); end
      step();
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL redir_flush: got %0b want 0", out_valid); end
    n_cmp++; if (im_addr !== 32'h40) begin n_err++; $display("[TB] FAIL redir_addr: got %h want 00000040", im_addr); end
    exp_q.push_back(32'h40);
    step();
    exp_pc = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL redir_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("[TB] FAIL redir_pc: got %h want %h", out_pc, exp_pc); end
    n_cmp++; if (out_instr !== (exp_pc >> 2)) begin n_err++; $display("[TB] FAIL redir_instr: got %h want %h", out_instr, exp_pc >> 2); end
    step();
    n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("[TB] FAIL redir_hold: got %h want 00000040", out_pc); end
  endtask

  task automatic test_halt();
    apply_reset(1'b0);
    repeat (3) step();
    halt      = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    for (int i = 0; i < 2; i++) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL halt_drain_valid[%0d]: got %0b want 1", i, out_valid); end
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("[TB] FAIL halt_drain_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_empty: got %0b want 0", out_valid); end
    n_cmp++; if (im_addr !== 32'd8) begin n_err++; $display("[TB] FAIL halt_pc_frozen: got %h want 00000008", im_addr); end
    n_cmp++; if (out_pc !== 32'd4) begin n_err++; $display("[TB] FAIL halt_out_hold: got %h want 00000004", out_pc); end
    repeat (2) step();
    n_cmp++; if (im_addr !== 32'd8) begin n_err++; $display("[TB] FAIL halt_pc_still: got %h want 00000008", im_addr); end
    halt = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL resume_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'd8) begin n_err++; $display("[TB] FAIL resume_pc: got %h want 00000008", out_pc); end
    n_cmp++; if (out_instr !== 32'd2) begin n_err++; $display("[TB] FAIL resume_instr: got %h want 00000002", out_instr); end
    // Redirect while halted still moves the pc and flushes.
    halt           = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (im_addr !== 32'h100) begin n_err++; $display("[TB] FAIL halt_redir_addr: got %h want 00000100", im_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_redir_flush: got %0b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_redir_nofetch: got %0b want 0", out_valid); end
    halt = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (im_addr !== 32'hFFFF_FFF8) begin n_err++; $display("[TB] FAIL wrap_addr: got %h want fffffff8", im_addr); end
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_q.pop_front();
      n_cmp++; if (out_pc !== exp_pc) begin n_err++; $display("[TB] FAIL wrap_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc >> 2)) begin n_err++; $display("[TB] FAIL wrap_instr[%0d]: got %h want %h", i, out_instr, exp_pc >> 2); end
    end
    n_cmp++; if (im_addr !== 32'd4) begin n_err++; $display("[TB] FAIL wrap_next_addr: got %h want 00000004", im_addr); end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    repeat (3) step();
    out_ready = 1'b0;
    step();
    n_cmp++; if (im_addr !== 32'd16) begin n_err++; $display("[TB] FAIL areset_pre_addr: got %h want 00000010", im_addr); end
    n_cmp++; if (out_pc !== 32'd8) begin n_err++; $display("[TB] FAIL areset_pre_head: got %h want 00000008", out_pc); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL areset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (im_addr !== 32'd0) begin n_err++; $display("[TB] FAIL areset_addr: got %h want 00000000", im_addr); end
    n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("[TB] FAIL areset_out_pc: got %h want 00000000", out_pc); end
    n_cmp++; if (out_instr !== 32'd0) begin n_err++; $display("[TB] FAIL areset_out_instr: got %h want 00000000", out_instr); end
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL areset_refetch_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("[TB] FAIL areset_refetch_pc: got %h want 00000000", out_pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
